// File: rtl/bridge_pkg.sv
// Shared constants and state encoding for the UART-to-memory command bridge.
package bridge_pkg;

    localparam logic [7:0] OPC_WRITE = 8'h01;
    localparam logic [7:0] OPC_READ  = 8'h02;
    localparam int unsigned HDR_IDX_W = 2;

    typedef enum logic [3:0] {
        StIdle, StHdr, StWdata, StWmem, StAck, StRreq, StRwait, StTx, StDone
    } state_t;

endpackage

// File: rtl/byte_serializer.sv
// Splits a 32-bit word into four little-endian bytes on a stb/ack handshake.
module byte_serializer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [31:0] word_i,
    input  logic        ack_i,
    output logic        stb_o,
    output logic [7:0]  data_o,
    output logic        done_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;
    logic        active_q, active_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q   <= '0;
            idx_q    <= '0;
            active_q <= 1'b0;
        end else begin
            word_q   <= word_d;
            idx_q    <= idx_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        word_d   = word_q;
        idx_d    = idx_q;
        active_d = active_q;
        done_o   = active_q && ack_i && (idx_q == 2'd3);
        if (load_i) begin
            word_d   = word_i;
            idx_d    = '0;
            active_d = 1'b1;
        end else if (active_q && ack_i) begin
            // Shifting right keeps the byte being offered in bits 7:0.
            word_d = {8'h00, word_q[31:8]};
            idx_d  = idx_q + 2'd1;
            if (idx_q == 2'd3) active_d = 1'b0;
        end
    end

    assign stb_o  = active_q;
    assign data_o = word_q[7:0];

endmodule

// File: rtl/uart_mem_bridge.sv
// Opcode-driven bridge moving 32-bit words between UART byte streams and memory port b.
module uart_mem_bridge
    import bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
    parameter logic [7:0]  ACK_BYTE       = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_stb,
    output logic [7:0]            tx_data,
    output logic                  tx_stb,
    input  logic                  tx_ack,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_dw,
    input  logic [31:0]           mem_dr,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                 state_q, state_d;
    logic                   is_read_q, is_read_d;
    logic [HDR_IDX_W-1:0]   hdr_idx_q, hdr_idx_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [31:0]            word_q, word_d;
    logic [1:0]             wbyte_q, wbyte_d;
    logic [TmoW-1:0]        tmo_q, tmo_d;
    logic                   err_q, err_d;

    logic        collecting, timeout_hit, ser_load, ser_stb, ser_done;
    logic [7:0]  ser_data;
    logic [15:0] cnt_new;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            is_read_q <= 1'b0;
            hdr_idx_q <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            word_q    <= '0;
            wbyte_q   <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_read_q <= is_read_d;
            hdr_idx_q <= hdr_idx_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            wbyte_q   <= wbyte_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
        end
    end

    assign collecting  = (state_q == StHdr) || (state_q == StWdata);
    assign timeout_hit = collecting && !rx_stb && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
    assign cnt_new     = {cnt_q[15:8], rx_data};

    always_comb begin
        state_d   = state_q;
        is_read_d = is_read_q;
        hdr_idx_d = hdr_idx_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        wbyte_d   = wbyte_q;
        err_d     = err_q;
        ser_load  = 1'b0;

        if (rx_stb)          tmo_d = '0;
        else if (collecting) tmo_d = tmo_q + TmoW'(1);
        else                 tmo_d = '0;

        unique case (state_q)
            StIdle: begin
                if (rx_stb && (rx_data == OPC_WRITE || rx_data == OPC_READ)) begin
                    is_read_d = (rx_data == OPC_READ);
                    hdr_idx_d = '0;
                    state_d   = StHdr;
                end
            end
            StHdr: begin
                if (timeout_hit) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else if (rx_stb) begin
                    hdr_idx_d = hdr_idx_q + HDR_IDX_W'(1);
                    unique case (hdr_idx_q)
                        2'd0: addr_d = ADDR_WIDTH'({rx_data, 8'h00});
                        2'd1: addr_d = addr_q | ADDR_WIDTH'(rx_data);
                        2'd2: cnt_d  = {rx_data, 8'h00};
                        default: begin
                            cnt_d   = cnt_new;
                            wbyte_d = '0;
                            if (is_read_q) state_d = (cnt_new == '0) ? StIdle : StRreq;
                            else           state_d = (cnt_new == '0) ? StAck : StWdata;
                        end
                    endcase
                end
            end
            StWdata: begin
                if (timeout_hit) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else if (rx_stb) begin
                    // First byte ends up in bits 7:0 after four shifts.
                    word_d  = {rx_data, word_q[31:8]};
                    wbyte_d = wbyte_q + 2'd1;
                    if (wbyte_q == 2'd3) state_d = StWmem;
                end
            end
            StWmem: begin
                addr_d  = addr_q + ADDR_WIDTH'(1);
                cnt_d   = cnt_q - 16'd1;
                state_d = (cnt_q == 16'd1) ? StAck : StWdata;
            end
            StAck:   if (tx_ack) state_d = StIdle;
            StRreq:  state_d = StRwait;
            StRwait: begin
                ser_load = 1'b1;
                state_d  = StTx;
            end
            StTx:    if (ser_done) state_d = StDone;
            StDone: begin
                addr_d  = addr_q + ADDR_WIDTH'(1);
                cnt_d   = cnt_q - 16'd1;
                state_d = (cnt_q == 16'd1) ? StIdle : StRreq;
            end
            default: state_d = StIdle;
        endcase

        if (rx_stb && (state_q inside {StAck, StRreq, StRwait, StTx, StDone})) err_d = 1'b1;
    end

    byte_serializer u_ser (
        .clk_i  (clk),
        .rst_ni (reset),
        .load_i (ser_load),
        .word_i (mem_dr),
        .ack_i  (tx_ack && (state_q == StTx)),
        .stb_o  (ser_stb),
        .data_o (ser_data),
        .done_o (ser_done)
    );

    assign tx_stb   = (state_q == StAck) || ser_stb;
    assign tx_data  = (state_q == StAck) ? ACK_BYTE : (ser_stb ? ser_data : 8'h00);
    assign mem_en   = (state_q == StWmem) || (state_q == StRreq);
    assign mem_we   = (state_q == StWmem);
    assign mem_addr = addr_q;
    assign mem_dw   = word_q;
    assign busy     = (state_q != StIdle);
    assign err      = err_q;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed plus randomized bench for uart_mem_bridge with memory and UART-tx models.
module tb_uart_mem_bridge;

    localparam int unsigned TMO = 300;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_stb = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_stb;
    logic        tx_ack = 1'b0;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_dw;
    logic [31:0] mem_dr = 32'h0;
    logic        busy, err;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int en_cnt = 0;
    int viol = 0;
    int stab_err = 0;

    logic [31:0] bmem [0:65535];
    logic [31:0] exp_mem [int];
    logic [7:0]  byte_q [$];

    always #5 clk = ~clk;

    uart_mem_bridge #(
        .ADDR_WIDTH     (16),
        .TIMEOUT_CYCLES (TMO),
        .ACK_BYTE       (8'hA5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_stb   (rx_stb),
        .tx_data  (tx_data),
        .tx_stb   (tx_stb),
        .tx_ack   (tx_ack),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_dw   (mem_dw),
        .mem_dr   (mem_dr),
        .busy     (busy),
        .err      (err)
    );

    // Memory port b: synchronous write, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en && mem_we) bmem[mem_addr] <= mem_dw;
        if (mem_en && !mem_we) mem_dr <= bmem[mem_addr];
        if (mem_en) en_cnt <= en_cnt + 1;
        if (mem_en && mem_we) wr_cnt <= wr_cnt + 1;
        if ((mem_we && !mem_en) || (mem_en && !busy)) viol <= viol + 1;
    end

    // UART transmitter model: random acceptance delay, checks stability while waiting.
    initial begin
        int wcnt;
        logic [7:0] held;
        wcnt = -1;
        held = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset) begin
                tx_ack = 1'b0;
                wcnt = -1;
            end else if (tx_ack) begin
                tx_ack = 1'b0;
            end else if (tx_stb) begin
                if (wcnt < 0) begin
                    wcnt = int'($urandom_range(0, 20));
                    held = tx_data;
                end else if (tx_data !== held) begin
                    stab_err++;
                end
                if (wcnt == 0) begin
                    tx_ack = 1'b1;
                    byte_q.push_back(tx_data);
                    wcnt = -1;
                end else begin
                    wcnt--;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_stb  = 1'b1;
        @(negedge clk);
        rx_stb  = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] opc, input logic [15:0] addr, input logic [15:0] cnt);
        send_byte(opc);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
        send_byte(cnt[15:8]);
        send_byte(cnt[7:0]);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || tx_stb) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " idle_bound"}, 64'(n < 20000), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_write(input string tag, input logic [15:0] addr, input logic [31:0] words[$]);
        int w0;
        w0 = wr_cnt;
        byte_q.delete();
        send_hdr(8'h01, addr, 16'(words.size()));
        foreach (words[i]) begin
            for (int k = 0; k < 4; k++) send_byte(words[i][8*k +: 8]);
            exp_mem[int'(16'(addr + 16'(i)))] = words[i];
        end
        wait_idle(tag);
        chk({tag, " ack_len"}, 64'(byte_q.size()), 64'd1);
        if (byte_q.size() > 0) chk({tag, " ack_byte"}, 64'(byte_q[0]), 64'hA5);
        chk({tag, " write_pulses"}, 64'(wr_cnt - w0), 64'(words.size()));
    endtask

    task automatic do_read(input string tag, input logic [15:0] addr, input int cnt);
        logic [31:0] w;
        byte_q.delete();
        send_hdr(8'h02, addr, 16'(cnt));
        wait_idle(tag);
        chk({tag, " rd_len"}, 64'(byte_q.size()), 64'(cnt * 4));
        for (int i = 0; i < cnt; i++) begin
            w = exp_mem[int'(16'(addr + 16'(i)))];
            for (int k = 0; k < 4; k++)
                if (i * 4 + k < byte_q.size())
                    chk($sformatf("%s rd_byte[%0d]", tag, i * 4 + k),
                        64'(byte_q[i * 4 + k]), 64'(w[8*k +: 8]));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({tx_stb, tx_data, mem_en, mem_we, mem_addr, mem_dw, busy, err}),
            64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        byte_q.delete();
    endtask

    initial begin
        logic [31:0] words[$];
        logic [15:0] a;
        int n, c, w0, e0;

        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({tx_stb, tx_data, mem_en, mem_we, mem_addr, mem_dw, busy, err}),
            64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        words = '{32'h44332211};
        do_write("wr_0010", 16'h0010, words);
        chk("wr_0010 mem", 64'(bmem[16'h0010]), 64'h44332211);
        chk("wr_0010 err", 64'(err), 64'd0);
        do_read("rd_0010", 16'h0010, 1);

        words = '{$urandom, $urandom};
        do_write("wr_wrap", 16'hFFFF, words);
        chk("wr_wrap mem_ffff", 64'(bmem[16'hFFFF]), 64'(words[0]));
        chk("wr_wrap mem_0000", 64'(bmem[16'h0000]), 64'(words[1]));
        do_read("rd_wrap", 16'hFFFF, 2);

        for (int t = 0; t < 5; t++) begin
            a = 16'($urandom);
            words.delete();
            c = int'($urandom_range(1, 4));
            for (int i = 0; i < c; i++) words.push_back($urandom);
            do_write($sformatf("rnd_wr%0d", t), a, words);
            do_read($sformatf("rnd_rd%0d", t), a, c);
        end

        words.delete();
        do_write("wr_cnt0", 16'h0040, words);
        do_read("rd_cnt0", 16'h0040, 0);
        chk("cnt0 busy", 64'(busy), 64'd0);

        // rx byte while a READ is transmitting: dropped, err set, read completes.
        byte_q.delete();
        send_hdr(8'h02, 16'h0010, 16'd1);
        n = 0;
        while (!tx_stb && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rx_in_tx stb_bound", 64'(n < 200), 64'd1);
        send_byte(8'h55);
        wait_idle("rx_in_tx");
        chk("rx_in_tx err", 64'(err), 64'd1);
        chk("rx_in_tx len", 64'(byte_q.size()), 64'd4);
        for (int k = 0; k < 4 && k < byte_q.size(); k++)
            chk($sformatf("rx_in_tx byte[%0d]", k), 64'(byte_q[k]), 64'(8'h11 * (k + 1)));

        do_reset();
        chk("after_reset err", 64'(err), 64'd0);

        // Timeout mid-word: no memory write, err set, back to idle.
        w0 = wr_cnt;
        send_hdr(8'h01, 16'h0020, 16'd1);
        send_byte(8'hDE);
        send_byte(8'hAD);
        repeat (TMO + 20) @(negedge clk);
        chk("tmo busy", 64'(busy), 64'd0);
        chk("tmo err", 64'(err), 64'd1);
        chk("tmo no_write", 64'(wr_cnt - w0), 64'd0);

        do_reset();

        send_byte(8'h7F);
        chk("opc7f busy", 64'(busy), 64'd0);
        chk("opc7f err", 64'(err), 64'd0);
        do_read("rd_after_7f", 16'h0010, 1);
        chk("rd_after_7f err", 64'(err), 64'd0);

        // Reset mid-READ: outputs forced to 0 and no further memory activity.
        words = '{$urandom, $urandom, $urandom};
        do_write("wr_pre_rst", 16'h0100, words);
        byte_q.delete();
        send_hdr(8'h02, 16'h0100, 16'd3);
        n = 0;
        while (!tx_stb && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mid_rd stb_bound", 64'(n < 200), 64'd1);
        reset = 1'b0;
        #1;
        chk("mid_rd reset_outputs",
            64'({tx_stb, tx_data, mem_en, mem_we, mem_addr, mem_dw, busy, err}), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        e0 = en_cnt;
        byte_q.delete();
        repeat (30) @(negedge clk);
        chk("mid_rd busy", 64'(busy), 64'd0);
        chk("mid_rd no_mem", 64'(en_cnt - e0), 64'd0);
        chk("mid_rd no_tx", 64'(byte_q.size()), 64'd0);

        chk("tx_stable", 64'(stab_err), 64'd0);
        chk("mem_en_only_when_busy", 64'(viol), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
